// File: rtl/mem_arb_pkg.sv
// Shared definitions for the instruction/data memory arbiter.
// Optional build macro MEM_ARB_RR_EN selects round-robin arbitration in mem_arbiter.
`ifndef XLEN
`define XLEN 32
`endif

package mem_arb_pkg;

    localparam int XLEN = `XLEN;

    // Source ID stored per outstanding read
    localparam logic SRC_IRAM = 1'b0;
    localparam logic SRC_DRAM = 1'b1;

    typedef struct packed {
        logic              write;
        logic [XLEN/8-1:0] wstrb;
        logic [XLEN-1:0]   addr;
        logic [XLEN-1:0]   wdata;
    } mem_req_t;

endpackage

// File: rtl/mem_arb_id_fifo.sv
// Small synchronous FIFO holding the requester ID of each read in flight.
// Pushes are refused when full and pops are ignored when empty.
module mem_arb_id_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 1,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    // Explicit wrap keeps the pointers correct for any depth, not only powers of two
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between the instruction and data requesters, returning read data in order.
// Define MEM_ARB_RR_EN for round-robin arbitration; otherwise dram has fixed priority.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 4,
    parameter int XLEN_P          = `XLEN
) (
    input  logic                clk,
    input  logic                rst_b,

    input  logic                iram_req,
    input  logic                iram_write,
    input  logic [XLEN_P/8-1:0] iram_wstrb,
    input  logic [XLEN_P-1:0]   iram_addr,
    input  logic [XLEN_P-1:0]   iram_wdata,
    output logic                iram_ready,
    output logic                iram_rvalid,
    output logic [XLEN_P-1:0]   iram_rdata,

    input  logic                dram_req,
    input  logic                dram_write,
    input  logic [XLEN_P/8-1:0] dram_wstrb,
    input  logic [XLEN_P-1:0]   dram_addr,
    input  logic [XLEN_P-1:0]   dram_wdata,
    output logic                dram_ready,
    output logic                dram_rvalid,
    output logic [XLEN_P-1:0]   dram_rdata,

    output logic                mem_req,
    output logic                mem_write,
    output logic [XLEN_P/8-1:0] mem_wstrb,
    output logic [XLEN_P-1:0]   mem_addr,
    output logic [XLEN_P-1:0]   mem_wdata,
    input  logic                mem_ready,
    input  logic                mem_rvalid,
    input  logic [XLEN_P-1:0]   mem_rdata
);

    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

    // Same layout as mem_req_t, sized by this instance's width
    typedef struct packed {
        logic                write;
        logic [XLEN_P/8-1:0] wstrb;
        logic [XLEN_P-1:0]   addr;
        logic [XLEN_P-1:0]   wdata;
    } req_bundle_t;

    req_bundle_t      iram_bundle;
    req_bundle_t      dram_bundle;
    req_bundle_t      win;
    logic             sel_dram;
    logic             stall;
    logic             mem_go;
    logic             accept;
    logic             push;
    logic             rsp_ok;
    logic             head_id;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CNT_W-1:0] outstanding;

    assign iram_bundle = '{write: iram_write, wstrb: iram_wstrb, addr: iram_addr, wdata: iram_wdata};
    assign dram_bundle = '{write: dram_write, wstrb: dram_wstrb, addr: dram_addr, wdata: dram_wdata};

`ifdef MEM_ARB_RR_EN
    logic last_grant;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            last_grant <= SRC_DRAM;
        end else if (accept) begin
            last_grant <= sel_dram ? SRC_DRAM : SRC_IRAM;
        end
    end

    always_comb begin
        sel_dram = dram_req;
        if (iram_req && dram_req) begin
            sel_dram = (last_grant == SRC_IRAM);
        end
    end
`else
    assign sel_dram = dram_req;
`endif

    // Writes are blocked too when the ID FIFO is full, so issue order stays trivial
    assign stall  = (outstanding == CNT_W'(MAX_OUTSTANDING));
    assign win    = sel_dram ? dram_bundle : iram_bundle;
    assign mem_go = rst_b && (iram_req || dram_req) && !stall;
    assign accept = mem_go && mem_ready;
    assign push   = accept && !win.write && !fifo_full;

    assign mem_req    = mem_go;
    assign mem_write  = win.write;
    assign mem_wstrb  = win.wstrb;
    assign mem_addr   = win.addr;
    assign mem_wdata  = win.wdata;
    assign iram_ready = accept && !sel_dram;
    assign dram_ready = accept && sel_dram;

    mem_arb_id_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .WIDTH (1),
        .CNT_W (CNT_W)
    ) u_id_fifo (
        .clk       (clk),
        .rst_b     (rst_b),
        .push      (push),
        .push_data (sel_dram ? SRC_DRAM : SRC_IRAM),
        .pop       (mem_rvalid),
        .pop_data  (head_id),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (outstanding)
    );

    // Responses arriving with nothing outstanding are dropped
    assign rsp_ok      = rst_b && mem_rvalid && !fifo_empty;
    assign iram_rvalid = rsp_ok && (head_id == SRC_IRAM);
    assign dram_rvalid = rsp_ok && (head_id == SRC_DRAM);
    assign iram_rdata  = iram_rvalid ? mem_rdata : '0;
    assign dram_rdata  = dram_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized traffic
// checked against a queue-based reference model. Honours MEM_ARB_RR_EN when defined.
module tb_mem_arbiter;

    localparam int MAXO = 4;

    logic        clk;
    logic        rst_b;
    logic        iram_req, iram_write, iram_ready, iram_rvalid;
    logic [3:0]  iram_wstrb;
    logic [31:0] iram_addr, iram_wdata, iram_rdata;
    logic        dram_req, dram_write, dram_ready, dram_rvalid;
    logic [3:0]  dram_wstrb;
    logic [31:0] dram_addr, dram_wdata, dram_rdata;
    logic        mem_req, mem_write, mem_ready, mem_rvalid;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    int total = 0;
    int bad   = 0;

    mem_arbiter #(.MAX_OUTSTANDING(MAXO), .XLEN_P(32)) dut (
        .clk(clk), .rst_b(rst_b),
        .iram_req(iram_req), .iram_write(iram_write), .iram_wstrb(iram_wstrb),
        .iram_addr(iram_addr), .iram_wdata(iram_wdata), .iram_ready(iram_ready),
        .iram_rvalid(iram_rvalid), .iram_rdata(iram_rdata),
        .dram_req(dram_req), .dram_write(dram_write), .dram_wstrb(dram_wstrb),
        .dram_addr(dram_addr), .dram_wdata(dram_wdata), .dram_ready(dram_ready),
        .dram_rvalid(dram_rvalid), .dram_rdata(dram_rdata),
        .mem_req(mem_req), .mem_write(mem_write), .mem_wstrb(mem_wstrb),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ready(mem_ready),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic idle_inputs();
        iram_req = 0; iram_write = 0; iram_wstrb = 0; iram_addr = 0; iram_wdata = 0;
        dram_req = 0; dram_write = 0; dram_wstrb = 0; dram_addr = 0; dram_wdata = 0;
        mem_ready = 0; mem_rvalid = 0; mem_rdata = 0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_b = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_b = 1'b1;
    endtask

    // Outputs must stay quiet while reset is held, even with requests pending
    task automatic test_reset();
        idle_inputs();
        rst_b = 1'b0;
        iram_req = 1; dram_req = 1; mem_ready = 1; mem_rvalid = 1; mem_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        total++; if (mem_req !== 1'b0) begin bad++; $display("[TB] FAIL reset_mem_req got=%b exp=0", mem_req); end
        total++; if (iram_ready !== 1'b0) begin bad++; $display("[TB] FAIL reset_iram_ready got=%b exp=0", iram_ready); end
        total++; if (dram_ready !== 1'b0) begin bad++; $display("[TB] FAIL reset_dram_ready got=%b exp=0", dram_ready); end
        total++; if (iram_rvalid !== 1'b0 || dram_rvalid !== 1'b0) begin
            bad++; $display("[TB] FAIL reset_rvalid got=%b%b exp=00", iram_rvalid, dram_rvalid);
        end
        total++; if (iram_rdata !== 32'h0 || dram_rdata !== 32'h0) begin
            bad++; $display("[TB] FAIL reset_rdata got=%h/%h exp=0/0", iram_rdata, dram_rdata);
        end
        do_reset();
    endtask

    task automatic test_single_read();
        iram_req = 1; iram_write = 0; iram_addr = 32'h100; mem_ready = 1;
        @(negedge clk);
        total++; if (mem_req !== 1'b1 || mem_addr !== 32'h100 || mem_write !== 1'b0) begin
            bad++; $display("[TB] FAIL single_issue got req=%b addr=%h wr=%b exp req=1 addr=100 wr=0", mem_req, mem_addr, mem_write);
        end
        total++; if (iram_ready !== 1'b1 || dram_ready !== 1'b0) begin
            bad++; $display("[TB] FAIL single_ready got=%b%b exp=10", iram_ready, dram_ready);
        end
        next_cycle();
        iram_req = 0; mem_ready = 0;
        next_cycle();
        mem_rvalid = 1; mem_rdata = 32'hDEADBEEF;
        @(negedge clk);
        total++; if (iram_rvalid !== 1'b1 || iram_rdata !== 32'hDEADBEEF) begin
            bad++; $display("[TB] FAIL single_resp got rv=%b data=%h exp rv=1 data=deadbeef", iram_rvalid, iram_rdata);
        end
        total++; if (dram_rvalid !== 1'b0 || dram_rdata !== 32'h0) begin
            bad++; $display("[TB] FAIL single_other got rv=%b data=%h exp rv=0 data=0", dram_rvalid, dram_rdata);
        end
        next_cycle();
        mem_rvalid = 0; mem_rdata = 0;
    endtask

    // A lone dram write first makes dram the last grant, so the RR build must favour iram
    task automatic test_priority();
        bit first_dram;
        logic fr, sr;
        logic [31:0] fd, sd;
`ifdef MEM_ARB_RR_EN
        first_dram = 0;
`else
        first_dram = 1;
`endif
        dram_req = 1; dram_write = 1; dram_wstrb = 4'hF; dram_addr = 32'h50; dram_wdata = 32'h1; mem_ready = 1;
        next_cycle();
        dram_write = 0; dram_addr = 32'h500;
        iram_req = 1; iram_write = 0; iram_addr = 32'h400;
        @(negedge clk);
        total++; if ((first_dram ? dram_ready : iram_ready) !== 1'b1 || (first_dram ? iram_ready : dram_ready) !== 1'b0) begin
            bad++; $display("[TB] FAIL prio_first got i=%b d=%b exp dram_first=%0d", iram_ready, dram_ready, first_dram);
        end
        total++; if (mem_addr !== (first_dram ? 32'h500 : 32'h400)) begin
            bad++; $display("[TB] FAIL prio_first_addr got=%h exp=%h", mem_addr, first_dram ? 32'h500 : 32'h400);
        end
        next_cycle();
        if (first_dram) dram_req = 0; else iram_req = 0;
        @(negedge clk);
        total++; if ((first_dram ? iram_ready : dram_ready) !== 1'b1) begin
            bad++; $display("[TB] FAIL prio_second got i=%b d=%b exp second granted", iram_ready, dram_ready);
        end
        next_cycle();
        iram_req = 0; dram_req = 0; mem_ready = 0;
        mem_rvalid = 1; mem_rdata = 32'h11;
        @(negedge clk);
        fr = first_dram ? dram_rvalid : iram_rvalid; fd = first_dram ? dram_rdata : iram_rdata;
        sr = first_dram ? iram_rvalid : dram_rvalid;
        total++; if (fr !== 1'b1 || fd !== 32'h11 || sr !== 1'b0) begin
            bad++; $display("[TB] FAIL prio_resp1 got rv=%b data=%h other=%b exp rv=1 data=11 other=0", fr, fd, sr);
        end
        next_cycle();
        mem_rdata = 32'h22;
        @(negedge clk);
        sr = first_dram ? iram_rvalid : dram_rvalid; sd = first_dram ? iram_rdata : dram_rdata;
        fr = first_dram ? dram_rvalid : iram_rvalid;
        total++; if (sr !== 1'b1 || sd !== 32'h22 || fr !== 1'b0) begin
            bad++; $display("[TB] FAIL prio_resp2 got rv=%b data=%h other=%b exp rv=1 data=22 other=0", sr, sd, fr);
        end
        next_cycle();
        mem_rvalid = 0; mem_rdata = 0;
    endtask

    task automatic test_stall();
        iram_req = 1; iram_write = 0; mem_ready = 1;
        for (int k = 0; k < MAXO; k++) begin
            iram_addr = 32'h200 + 32'(4 * k);
            @(negedge clk);
            total++; if (iram_ready !== 1'b1) begin bad++; $display("[TB] FAIL stall_fill%0d got=%b exp=1", k, iram_ready); end
            next_cycle();
        end
        iram_addr = 32'h210;
        @(negedge clk);
        total++; if (iram_ready !== 1'b0 || mem_req !== 1'b0) begin
            bad++; $display("[TB] FAIL stall_full got ready=%b req=%b exp 0/0", iram_ready, mem_req);
        end
        next_cycle();
        mem_rvalid = 1; mem_rdata = 32'h1000;
        @(negedge clk);
        total++; if (iram_rvalid !== 1'b1 || iram_rdata !== 32'h1000 || iram_ready !== 1'b0) begin
            bad++; $display("[TB] FAIL stall_pop got rv=%b data=%h ready=%b exp 1/1000/0", iram_rvalid, iram_rdata, iram_ready);
        end
        next_cycle();
        mem_rvalid = 0; mem_rdata = 0;
        @(negedge clk);
        total++; if (iram_ready !== 1'b1 || mem_req !== 1'b1 || mem_addr !== 32'h210) begin
            bad++; $display("[TB] FAIL stall_resume got ready=%b req=%b addr=%h exp 1/1/210", iram_ready, mem_req, mem_addr);
        end
        next_cycle();
        iram_req = 0; mem_ready = 0;
        for (int k = 0; k < MAXO; k++) begin
            mem_rvalid = 1; mem_rdata = 32'h2000 + 32'(k);
            @(negedge clk);
            total++; if (iram_rvalid !== 1'b1 || iram_rdata !== 32'h2000 + 32'(k)) begin
                bad++; $display("[TB] FAIL stall_drain%0d got rv=%b data=%h exp rv=1 data=%h", k, iram_rvalid, iram_rdata, 32'h2000 + 32'(k));
            end
            next_cycle();
        end
        mem_rvalid = 0; mem_rdata = 0;
    endtask

    task automatic test_write_hold();
        dram_req = 1; dram_write = 1; dram_wstrb = 4'b0011; dram_addr = 32'h300; dram_wdata = 32'hA5A5; mem_ready = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            total++; if (dram_ready !== 1'b0 || mem_req !== 1'b1 || mem_write !== 1'b1 ||
                         mem_wstrb !== 4'b0011 || mem_wdata !== 32'hA5A5 || mem_addr !== 32'h300) begin
                bad++; $display("[TB] FAIL write_hold%0d got ready=%b req=%b wr=%b strb=%b wdata=%h addr=%h exp 0/1/1/0011/a5a5/300",
                                k, dram_ready, mem_req, mem_write, mem_wstrb, mem_wdata, mem_addr);
            end
            next_cycle();
        end
        mem_ready = 1;
        @(negedge clk);
        total++; if (dram_ready !== 1'b1) begin bad++; $display("[TB] FAIL write_accept got=%b exp=1", dram_ready); end
        next_cycle();
        dram_req = 0; dram_write = 0; mem_ready = 0;
        mem_rvalid = 1; mem_rdata = 32'h77;
        @(negedge clk);
        total++; if (dram_rvalid !== 1'b0 || iram_rvalid !== 1'b0 || dram_rdata !== 32'h0) begin
            bad++; $display("[TB] FAIL write_noresp got rv=%b%b data=%h exp 00/0", iram_rvalid, dram_rvalid, dram_rdata);
        end
        next_cycle();
        mem_rvalid = 0; mem_rdata = 0;
    endtask

    task automatic test_reset_mid();
        iram_req = 1; iram_write = 0; iram_addr = 32'h600; mem_ready = 1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            total++; if (iram_ready !== 1'b1) begin bad++; $display("[TB] FAIL rstmid_issue%0d got=%b exp=1", k, iram_ready); end
            next_cycle();
        end
        do_reset();
        for (int k = 0; k < 2; k++) begin
            mem_rvalid = 1; mem_rdata = 32'hBAD0 + 32'(k);
            @(negedge clk);
            total++; if (iram_rvalid !== 1'b0 || dram_rvalid !== 1'b0 || iram_rdata !== 32'h0) begin
                bad++; $display("[TB] FAIL rstmid_spurious%0d got rv=%b%b data=%h exp 00/0", k, iram_rvalid, dram_rvalid, iram_rdata);
            end
            next_cycle();
        end
        mem_rvalid = 0; mem_rdata = 0;
        // Accepting a full set of reads proves nothing survived the reset
        iram_req = 1; mem_ready = 1;
        for (int k = 0; k < MAXO; k++) begin
            iram_addr = 32'h700 + 32'(4 * k);
            @(negedge clk);
            total++; if (iram_ready !== 1'b1) begin bad++; $display("[TB] FAIL rstmid_refill%0d got=%b exp=1", k, iram_ready); end
            next_cycle();
        end
        iram_req = 0; mem_ready = 0;
        for (int k = 0; k < MAXO; k++) begin
            mem_rvalid = 1; mem_rdata = 32'h3000 + 32'(k);
            @(negedge clk);
            total++; if (iram_rvalid !== 1'b1 || iram_rdata !== 32'h3000 + 32'(k)) begin
                bad++; $display("[TB] FAIL rstmid_resp%0d got rv=%b data=%h exp 1/%h", k, iram_rvalid, iram_rdata, 32'h3000 + 32'(k));
            end
            next_cycle();
        end
        mem_rvalid = 0; mem_rdata = 0;
    endtask

    // Reference model: a queue of requester IDs for reads in flight plus the last grant
    task automatic test_random();
        bit   src_q[$];
        bit   last_dram;
        bit   win_dram, exp_req, exp_ir, exp_dr, exp_irv, exp_drv, do_pop;
        logic [31:0] exp_addr, exp_wdata;
        logic [3:0]  exp_wstrb;
        logic        exp_write;
        do_reset();
        last_dram = 1;
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (!iram_req && $urandom_range(0, 99) < 50) begin
                iram_req = 1; iram_write = ($urandom_range(0, 3) == 0); iram_wstrb = 4'($urandom);
                iram_addr = $urandom; iram_wdata = $urandom;
            end
            if (!dram_req && $urandom_range(0, 99) < 50) begin
                dram_req = 1; dram_write = ($urandom_range(0, 3) == 0); dram_wstrb = 4'($urandom);
                dram_addr = $urandom; dram_wdata = $urandom;
            end
            mem_ready  = ($urandom_range(0, 99) < 70);
            mem_rvalid = ($urandom_range(0, 99) < 40);
            mem_rdata  = $urandom;
            @(negedge clk);
`ifdef MEM_ARB_RR_EN
            win_dram = (iram_req && dram_req) ? !last_dram : dram_req;
`else
            win_dram = dram_req;
`endif
            exp_req   = (iram_req || dram_req) && (src_q.size() < MAXO);
            exp_ir    = exp_req && mem_ready && !win_dram;
            exp_dr    = exp_req && mem_ready && win_dram;
            do_pop    = mem_rvalid && (src_q.size() > 0);
            exp_irv   = do_pop && (src_q[0] == 1'b0);
            exp_drv   = do_pop && (src_q[0] == 1'b1);
            exp_addr  = win_dram ? dram_addr : iram_addr;
            exp_wdata = win_dram ? dram_wdata : iram_wdata;
            exp_wstrb = win_dram ? dram_wstrb : iram_wstrb;
            exp_write = win_dram ? dram_write : iram_write;
            total++; if (mem_req !== exp_req) begin bad++; $display("[TB] FAIL rand_mem_req cyc=%0d got=%b exp=%b", cyc, mem_req, exp_req); end
            total++; if (iram_ready !== exp_ir || dram_ready !== exp_dr) begin
                bad++; $display("[TB] FAIL rand_ready cyc=%0d got=%b%b exp=%b%b", cyc, iram_ready, dram_ready, exp_ir, exp_dr);
            end
            total++; if (iram_rvalid !== exp_irv || dram_rvalid !== exp_drv) begin
                bad++; $display("[TB] FAIL rand_rvalid cyc=%0d got=%b%b exp=%b%b", cyc, iram_rvalid, dram_rvalid, exp_irv, exp_drv);
            end
            total++; if (iram_rdata !== (exp_irv ? mem_rdata : 32'h0) || dram_rdata !== (exp_drv ? mem_rdata : 32'h0)) begin
                bad++; $display("[TB] FAIL rand_rdata cyc=%0d got=%h/%h", cyc, iram_rdata, dram_rdata);
            end
            if (exp_req) begin
                total++; if (mem_addr !== exp_addr || mem_wdata !== exp_wdata || mem_wstrb !== exp_wstrb || mem_write !== exp_write) begin
                    bad++; $display("[TB] FAIL rand_bundle cyc=%0d got a=%h d=%h s=%b w=%b exp a=%h d=%h s=%b w=%b", cyc,
                                    mem_addr, mem_wdata, mem_wstrb, mem_write, exp_addr, exp_wdata, exp_wstrb, exp_write);
                end
            end
            next_cycle();
            if (do_pop) void'(src_q.pop_front());
            if (exp_ir || exp_dr) begin
                last_dram = win_dram;
                if (!exp_write) src_q.push_back(win_dram);
            end
            if (exp_ir) iram_req = 0;
            if (exp_dr) dram_req = 0;
        end
        idle_inputs();
    endtask

    initial begin
        $display("[TB] mem_arbiter bench start");
        test_reset();
        test_single_read();
        test_priority();
        test_stall();
        test_write_hold();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
